// File: rtl/gpio_cfg_pkg.sv
// Shared widths, channel addresses, FSM state and FIFO entry layout for the
// GPIO configuration write bridge.
package gpio_cfg_pkg;
  localparam int CONF0_W = 24;
  localparam int CONF1_W = 17;

  localparam logic ADDR_CONF0 = 1'b0;
  localparam logic ADDR_CONF1 = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic               addr;
    logic [CONF0_W-1:0] data;
  } cfg_entry_t;
endpackage

// File: rtl/gpio_cfg_fifo.sv
// Synchronous FIFO with asynchronous reset. ready_o is a registered !full,
// held low while reset is asserted.
module gpio_cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     ready_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && ready_q;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)
      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok)
      level_d = level_q - LVL_W'(1);
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      ready_q <= (level_d != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
endmodule

// File: rtl/gpio_cfg_bridge.sv
// Buffers host config writes and replays them one at a time onto two one-shot
// valid/ready channels. GPIO_CFG_BRIDGE_TIMEOUT_EN adds an ISSUE watchdog and sticky err.
module gpio_cfg_bridge
  import gpio_cfg_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_addr,
  input  logic [CONF0_W-1:0]     req_data,
  output logic                   conf_0_valid,
  input  logic                   conf_0_ready,
  output logic [CONF0_W-1:0]     conf_0_in,
  output logic                   conf_1_valid,
  input  logic                   conf_1_ready,
  output logic [CONF1_W-1:0]     conf_1_in,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clr
);
  cfg_entry_t         push_entry, head;
  logic               fifo_empty, fifo_full_unused;
  logic               pop, handshake, timeout_hit;
  state_e             state_q;
  logic               sel_q;
  logic               c0_valid_q, c1_valid_q;
  logic [CONF0_W-1:0] c0_data_q;
  logic [CONF1_W-1:0] c1_data_q;

  assign push_entry.addr = req_addr;
  assign push_entry.data = req_data;

  gpio_cfg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cfg_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (req_valid),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .ready_o (req_ready),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign handshake = (state_q == ISSUE) &&
                     ((sel_q == ADDR_CONF1) ? (c1_valid_q && conf_1_ready)
                                            : (c0_valid_q && conf_0_ready));

`ifdef GPIO_CFG_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // A handshake on the final cycle wins over the abort.
  assign timeout_hit = (state_q == ISSUE) && !handshake &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop)
        cnt_q <= '0;
      else if (state_q == ISSUE)
        cnt_q <= cnt_q + CNT_W'(1);
      if (err_clr)
        err_q <= 1'b0;
      else if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr | (TIMEOUT == 0);
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Leaving ISSUE always lands in IDLE, which gives the mandatory gap cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= ADDR_CONF0;
      c0_valid_q <= 1'b0;
      c1_valid_q <= 1'b0;
      c0_data_q  <= '0;
      c1_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= ISSUE;
            sel_q   <= head.addr;
            if (head.addr == ADDR_CONF1) begin
              c1_valid_q <= 1'b1;
              c1_data_q  <= head.data[CONF1_W-1:0];
            end else begin
              c0_valid_q <= 1'b1;
              c0_data_q  <= head.data;
            end
          end
        end
        ISSUE: begin
          if (handshake || timeout_hit) begin
            state_q    <= IDLE;
            c0_valid_q <= 1'b0;
            c1_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign conf_0_valid = c0_valid_q;
  assign conf_0_in    = c0_data_q;
  assign conf_1_valid = c1_valid_q;
  assign conf_1_in    = c1_data_q;
  assign busy         = !fifo_empty || (state_q == ISSUE);
endmodule

// File: tb/tb_gpio_cfg_bridge.sv
// Directed bench for gpio_cfg_bridge with a one-shot channel model on both
// configuration channels; covers both GPIO_CFG_BRIDGE_TIMEOUT_EN builds.
module tb_gpio_cfg_bridge;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_addr = 1'b0;
  logic [23:0] req_data = '0;
  logic        req_ready;
  logic        conf_0_valid, conf_0_ready;
  logic [23:0] conf_0_in;
  logic        conf_1_valid, conf_1_ready;
  logic [16:0] conf_1_in;
  logic [2:0]  fifo_level;
  logic        busy, err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        model_en = 1'b0;
  logic        rdy0, rdy1;
  int          cyc = 0;
  int          log_ch[$];
  logic [23:0] log_data[$];
  int          log_cyc[$];

  gpio_cfg_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .conf_0_valid(conf_0_valid), .conf_0_ready(conf_0_ready), .conf_0_in(conf_0_in),
    .conf_1_valid(conf_1_valid), .conf_1_ready(conf_1_ready), .conf_1_in(conf_1_in),
    .fifo_level(fifo_level), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  assign conf_0_ready = rdy0;
  assign conf_1_ready = rdy1;

  // Channel model: ready rises one cycle after valid, drops on the transfer edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy0 <= 1'b0;
      rdy1 <= 1'b0;
    end else begin
      if (conf_0_valid && rdy0) begin
        log_ch.push_back(0); log_data.push_back(conf_0_in); log_cyc.push_back(cyc);
      end
      if (conf_1_valid && rdy1) begin
        log_ch.push_back(1); log_data.push_back({7'b0, conf_1_in}); log_cyc.push_back(cyc);
      end
      rdy0 <= model_en && conf_0_valid && !rdy0;
      rdy1 <= model_en && conf_1_valid && !rdy1;
      cyc++;
    end
  end

  task automatic clear_log();
    log_ch.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic do_push(input logic a, input logic [23:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock); n++;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL push_accept: req_ready=%b required 1", req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clock); n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({req_ready, conf_0_valid, conf_1_valid, busy, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: {rdy,v0,v1,busy,err}=%b required 00000",
                         {req_ready, conf_0_valid, conf_1_valid, busy, err});
    end
    checks++;
    if (conf_0_in !== 24'h0 || conf_1_in !== 17'h0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_data: in0=%h in1=%h level=%0d required 0 0 0",
                         conf_0_in, conf_1_in, fifo_level);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: %b required 1", req_ready);
    end
  endtask

  task automatic test_single();
    int hi, first;
    hi = 0; first = -1;
    model_en = 1'b1;
    clear_log();
    do_push(1'b0, 24'hA5A5A5);
    for (int i = 0; i < 8; i++) begin
      if (conf_0_valid === 1'b1) begin
        hi++;
        if (first < 0) first = i;
      end
      checks++;
      if (conf_1_valid !== 1'b0) begin
        errors++; $display("FAIL single_v1: conf_1_valid=%b required 0", conf_1_valid);
      end
      @(negedge clock);
    end
    checks++;
    if (hi != 2) begin
      errors++; $display("FAIL single_valid_len: %0d cycles required 2", hi);
    end
    checks++;
    if (first != 1) begin
      errors++; $display("FAIL single_latency: valid first at %0d required 1", first);
    end
    checks++;
    if (conf_0_in !== 24'hA5A5A5) begin
      errors++; $display("FAIL single_data: conf_0_in=%h required a5a5a5", conf_0_in);
    end
    checks++;
    if (log_ch.size() != 1) begin
      errors++; $display("FAIL single_count: %0d transfers required 1", log_ch.size());
    end
  endtask

  task automatic test_burst();
    logic        a[5];
    logic [23:0] d[5];
    logic [23:0] exp_d[5];
    logic [2:0]  exp_lv[5];
    a      = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d      = '{24'h111111, 24'h3F0001, 24'h000333, 24'hFE4444, 24'hC0FFEE};
    exp_d  = '{24'h111111, 24'h010001, 24'h000333, 24'h004444, 24'hC0FFEE};
    exp_lv = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    model_en = 1'b0;
    clear_log();
    for (int i = 0; i < 5; i++) begin
      do_push(a[i], d[i]);
      checks++;
      if (fifo_level !== exp_lv[i]) begin
        errors++; $display("FAIL burst_level[%0d]: %0d required %0d", i, fifo_level, exp_lv[i]);
      end
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL burst_full_ready: %b required 0", req_ready);
    end
    model_en = 1'b1;
    wait_idle(100);
    checks++;
    if (fifo_level !== 3'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL burst_drain: level=%0d ready=%b required 0 1", fifo_level, req_ready);
    end
    checks++;
    if (log_ch.size() != 5) begin
      errors++; $display("FAIL burst_count: %0d transfers required 5", log_ch.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_ch[i] != int'(a[i]) || log_data[i] !== exp_d[i]) begin
          errors++; $display("FAIL burst_order[%0d]: ch%0d %h required ch%0d %h",
                             i, log_ch[i], log_data[i], a[i], exp_d[i]);
        end
        if (i > 0) begin
          checks++;
          if (log_cyc[i] - log_cyc[i-1] != 3) begin
            errors++; $display("FAIL burst_spacing[%0d]: %0d cycles required 3",
                               i, log_cyc[i] - log_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_interleave();
    model_en = 1'b1;
    clear_log();
    do_push(1'b1, 24'hFFFFFF);
    do_push(1'b0, 24'h000001);
    wait_idle(50);
    checks++;
    if (log_ch.size() != 2) begin
      errors++; $display("FAIL inter_count: %0d transfers required 2", log_ch.size());
    end else begin
      checks++;
      if (log_ch[0] != 1 || log_data[0] !== 24'h01FFFF) begin
        errors++; $display("FAIL inter_first: ch%0d %h required ch1 01ffff", log_ch[0], log_data[0]);
      end
      checks++;
      if (log_ch[1] != 0 || log_data[1] !== 24'h000001) begin
        errors++; $display("FAIL inter_second: ch%0d %h required ch0 000001", log_ch[1], log_data[1]);
      end
    end
    checks++;
    if (conf_1_in !== 17'h1FFFF || conf_0_in !== 24'h000001) begin
      errors++; $display("FAIL inter_hold: in1=%h in0=%h required 1ffff 000001", conf_1_in, conf_0_in);
    end
  endtask

  task automatic test_reset_mid();
    model_en = 1'b0;
    do_push(1'b0, 24'h0000AA);
    do_push(1'b0, 24'h0000BB);
    do_push(1'b0, 24'h0000CC);
    checks++;
    if (conf_0_valid !== 1'b1 || fifo_level !== 3'd2) begin
      errors++; $display("FAIL mid_setup: v0=%b level=%0d required 1 2", conf_0_valid, fifo_level);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({conf_0_valid, conf_1_valid, req_ready, busy} !== 4'b0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL mid_async: {v0,v1,rdy,busy}=%b level=%0d required 0000 0",
                         {conf_0_valid, conf_1_valid, req_ready, busy}, fifo_level);
    end
    checks++;
    if (conf_0_in !== 24'h0 || conf_1_in !== 17'h0) begin
      errors++; $display("FAIL mid_data: in0=%h in1=%h required 0 0", conf_0_in, conf_1_in);
    end
    @(negedge clock);
    clear_log();
    reset = 1'b0;
    model_en = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (log_ch.size() != 0 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL mid_after: transfers=%0d busy=%b level=%0d required 0 0 0",
                         log_ch.size(), busy, fifo_level);
    end
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    model_en = 1'b0;
    clear_log();
    do_push(1'b0, 24'h123456);
    do_push(1'b1, 24'h00ABCD);
    for (int i = 0; i < 12; i++) begin
      if (conf_0_valid === 1'b1) hi++;
      @(negedge clock);
    end
`ifdef GPIO_CFG_BRIDGE_TIMEOUT_EN
    checks++;
    if (hi != TIMEOUT) begin
      errors++; $display("FAIL to_valid_len: %0d cycles required %0d", hi, TIMEOUT);
    end
    checks++;
    if (err !== 1'b1 || conf_1_valid !== 1'b1) begin
      errors++; $display("FAIL to_err_next: err=%b v1=%b required 1 1", err, conf_1_valid);
    end
    model_en = 1'b1;
    wait_idle(50);
    checks++;
    if (log_ch.size() != 1) begin
      errors++; $display("FAIL to_count: %0d transfers required 1", log_ch.size());
    end else begin
      checks++;
      if (log_ch[0] != 1 || log_data[0] !== 24'h00ABCD) begin
        errors++; $display("FAIL to_next_data: ch%0d %h required ch1 00abcd", log_ch[0], log_data[0]);
      end
    end
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: err=%b required 1", err);
    end
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL to_clear: err=%b required 0", err);
    end
`else
    checks++;
    if (hi != 12 || conf_1_valid !== 1'b0) begin
      errors++; $display("FAIL nto_wait: valid cycles=%0d v1=%b required 12 0", hi, conf_1_valid);
    end
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL nto_err: err=%b required 0", err);
    end
    model_en = 1'b1;
    wait_idle(50);
    checks++;
    if (log_ch.size() != 2) begin
      errors++; $display("FAIL nto_count: %0d transfers required 2", log_ch.size());
    end else begin
      checks++;
      if (log_ch[0] != 0 || log_data[0] !== 24'h123456 ||
          log_ch[1] != 1 || log_data[1] !== 24'h00ABCD) begin
        errors++; $display("FAIL nto_order: ch%0d %h ch%0d %h required ch0 123456 ch1 00abcd",
                           log_ch[0], log_data[0], log_ch[1], log_data[1]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_interleave();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
